verilator_uart_tx: RTL and testbench
====================================

# verilator_uart_tx

Simulation-only UART transmitter that feeds the SoC's UART receive pin in the Verilator testbench. It sits directly upstream of the DUT `uart_rx_i`. The C++ harness pushes bytes through a valid/ready port into an internal FIFO, and the block serializes each byte as an 8N1 frame at a fixed bit period counted in `clk_i` cycles. It mirrors the existing receive-side monitor and uses the same bit-period convention, so the two loop back cleanly.

## Interface
- `BaudPeriodCycles`, default 1736: clock cycles per UART bit; legal values are ≥ 2.
- `FifoDepth`, default 16: byte FIFO entries; must be a power of two, ≥ 2.
- `StopBits`, default 1: number of stop bits per frame; 1 or 2.
- `clk_i`  in  1: clock. The block has one clock.
- `rst_ni`  in  1: reset, asynchronous, active-low.
- `data_valid_i`  in  1: byte offered by the harness.
- `data_i`  in  8: byte to transmit.
- `data_ready_o`  out  1: FIFO can accept a byte (not full).
- `uart_tx_o`  out  1: serial line to the DUT; idles high.
- `busy_o`  out  1: FIFO non-empty or a frame is in flight.
- `fifo_count_o`  out  $clog2(FifoDepth+1): current FIFO occupancy.

## Operation
- **Accept:** a byte is written when `data_valid_i && data_ready_o` at a rising edge.
  - `data_ready_o = !full`. There is no bypass, so a full FIFO with a same-cycle pop still reports not-ready.
  - `data_valid_i` is ignored while ready is low. The byte is not stored, and no error is raised.
- **FIFO:** circular buffer with read/write pointers of width $clog2(FifoDepth) that wrap modulo FifoDepth, plus an occupancy counter.
  - A simultaneous push and pop leaves the count unchanged.
- **FSM states:** IDLE, START, DATA, STOP.
  - **IDLE:** the line is high. If the FIFO is non-empty, pop into the shift register, clear the baud and bit counters, and go to START.
  - **START:** line low for BaudPeriodCycles cycles, then go to DATA.
  - **DATA:** drive `shift[0]`. Each bit lasts BaudPeriodCycles cycles, after which the register shifts right and the bit index increments. The 8 bits go out LSB first. After bit index 7 completes, go to STOP.
  - **STOP:** line high for StopBits×BaudPeriodCycles cycles. On the last STOP cycle:
    - if the FIFO is non-empty, pop and go directly to START (zero idle gap between frames);
    - otherwise go to IDLE.
- **Baud counter:** width $clog2(BaudPeriodCycles). It counts 0..BaudPeriodCycles−1; the terminal count advances the bit.
- **Stop-bit count:** counted with the same bit index, from 0 to StopBits−1.
- **Output register:** `uart_tx_o` is a flop output, so there is no combinational path from the inputs to the line.
- **Busy:** `busy_o = (state != IDLE) || (fifo_count_o != 0)`.

## Timing
- **Reset values:**
  - `uart_tx_o = 1` and `busy_o = 0`;
  - `fifo_count_o = 0` and `data_ready_o = 1`;
  - FSM in IDLE with all counters at 0.
- **Reset mid-frame:** the line returns high immediately and asynchronously, FIFO contents are discarded, and no partial frame resumes after reset is released.
- **Accept-to-line latency:** a byte accepted at edge t into an empty FIFO while IDLE gives `uart_tx_o` low after edge t+1. The first start-bit cycle is t+1..t+1+BaudPeriodCycles.
- **Frame length:** exactly (9+StopBits)×BaudPeriodCycles cycles. Back-to-back frames are contiguous.
- **Occupancy:** `fifo_count_o` updates one cycle after the accepting edge. The pop on the IDLE→START or STOP→START edge decrements it at that same edge.
- **Throughput:** with the FIFO kept non-empty, one byte per (9+StopBits)×BaudPeriodCycles cycles.

## Test plan
- **Single byte:** BaudPeriodCycles=8, push 0x55 while idle.
  - `uart_tx_o` low 1 cycle after accept.
  - Then bits 1,0,1,0,1,0,1,0, each 8 cycles.
  - Then high for 8 cycles.
  - `busy_o` drops after 80 cycles total.
- **Back-to-back:** push 0xA5 then 0x3C on consecutive cycles.
  - Second start bit begins on the cycle right after the first stop bit ends.
  - Line decodes as A5, 3C.
  - Total time 160 cycles.
- **FIFO full:** FifoDepth=16, hold valid for 20 cycles with distinct bytes 0x00..0x13.
  - Exactly 17 accepted: 1 popped immediately, then 16 fill the FIFO.
  - `data_ready_o` low once `fifo_count_o`=16.
  - Bytes transmitted in order 0x00..0x10; 0x11..0x13 never appear.
- **Reset mid-frame:** assert `rst_ni`=0 during DATA bit 3 of 0xFF with 4 bytes queued.
  - Line high during reset; count 0.
  - After release, the line stays high with no further frames.
- **Loopback:** connect `uart_tx_o` to the receive monitor with the same BaudPeriodCycles=1736 and send 256 random bytes, including 0x00 and 0xFF.
  - All received in order, with no framing gaps.
- **StopBits=2:** send 0x81.
  - Stop high lasts 16 cycles (at BaudPeriodCycles=8).
  - Frame length 88 cycles.

Source files
------------

// File: rtl/verilator_uart_tx.sv
// Purpose: byte FIFO feeding an 8N1 UART serializer that drives the line into the SoC UART receiver.
// Latency: a byte accepted into an empty, idle block starts its start bit one cycle after the accepting edge.
// Backpressure: data_ready_o is low while the FIFO is full; a same-cycle pop does not bypass into a full FIFO.
module verilator_uart_tx #(
  parameter int BaudPeriodCycles = 1736,
  parameter int FifoDepth        = 16,
  parameter int StopBits         = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             data_valid_i,
  input  logic [7:0]                       data_i,
  output logic                             data_ready_o,
  output logic                             uart_tx_o,
  output logic                             busy_o,
  output logic [$clog2(FifoDepth+1)-1:0]   fifo_count_o
);

  localparam int CntW  = $clog2(BaudPeriodCycles);
  localparam int PtrW  = $clog2(FifoDepth);
  localparam int OccW  = $clog2(FifoDepth+1);
  localparam logic [CntW-1:0] BaudLast = CntW'(BaudPeriodCycles - 1);
  localparam logic [2:0]      StopLast = 3'(StopBits - 1);
  localparam logic [OccW-1:0] OccFull  = OccW'(FifoDepth);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_n;
  logic [CntW-1:0]   baud_cnt, baud_n;
  logic [2:0]        bit_idx, bit_n;
  logic [7:0]        shift, shift_n;
  logic              line_n;
  logic [7:0]        mem [FifoDepth];
  logic [PtrW-1:0]   wr_ptr, rd_ptr;
  logic [OccW-1:0]   occ;
  logic              full, empty, push, pop, baud_done;
  logic [7:0]        rd_data;

  assign full         = (occ == OccFull);
  assign empty        = (occ == '0);
  assign push         = data_valid_i && !full;
  assign rd_data      = mem[rd_ptr];
  assign baud_done    = (baud_cnt == BaudLast);
  assign data_ready_o = !full;
  assign fifo_count_o = occ;
  assign busy_o       = (state != IDLE) || (occ != '0);

  // FIFO storage: written on every accepted byte, never reset (contents are don't-care when empty).
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= data_i;
  end

  // FIFO pointers and occupancy; simultaneous push and pop keeps the count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      occ <= occ + 1'b1;
      else if (pop && !push) occ <= occ - 1'b1;
    end
  end

  // Serializer state, counters and the registered line output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      uart_tx_o <= 1'b1;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_idx   <= bit_n;
      shift     <= shift_n;
      uart_tx_o <= line_n;
    end
  end

  // Next-state logic; the line value is derived from the next state so the flop shows it on entry.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt + 1'b1;
    bit_n   = bit_idx;
    shift_n = shift;
    pop     = 1'b0;
    line_n  = 1'b1;
    case (state)
      IDLE: begin
        baud_n = '0;
        bit_n  = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = rd_data;
          state_n = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_n  = '0;
          shift_n = shift >> 1;
          if (bit_idx == 3'd7) begin
            bit_n   = '0;
            state_n = STOP;
          end else begin
            bit_n = bit_idx + 1'b1;
          end
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_n = '0;
          if (bit_idx == StopLast) begin
            bit_n = '0;
            if (!empty) begin
              // Next frame starts with no idle gap.
              pop     = 1'b1;
              shift_n = rd_data;
              state_n = START;
            end else begin
              state_n = IDLE;
            end
          end else begin
            bit_n = bit_idx + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    case (state_n)
      START:   line_n = 1'b0;
      DATA:    line_n = shift_n[0];
      default: line_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_verilator_uart_tx.sv
// Directed bench for verilator_uart_tx at an 8-cycle bit period.
// Instance u0: one stop bit, 16-deep FIFO; instance u1: two stop bits, 4-deep FIFO.
// A frame decoder checks every cycle of each frame against the 8N1 shape.
module tb_verilator_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vld0 = 1'b0, vld1 = 1'b0;
  logic [7:0] dat0 = 8'h00, dat1 = 8'h00;
  logic       rdy0, tx0, busy0, rdy1, tx1, busy1;
  logic [4:0] cnt0;
  logic [2:0] cnt1;
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;

  verilator_uart_tx #(.BaudPeriodCycles(8), .FifoDepth(16), .StopBits(1)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .data_valid_i(vld0), .data_i(dat0),
    .data_ready_o(rdy0), .uart_tx_o(tx0), .busy_o(busy0), .fifo_count_o(cnt0));

  verilator_uart_tx #(.BaudPeriodCycles(8), .FifoDepth(4), .StopBits(2)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .data_valid_i(vld1), .data_i(dat1),
    .data_ready_o(rdy1), .uart_tx_o(tx1), .busy_o(busy1), .fifo_count_o(cnt1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  function automatic logic line(input int which);
    return (which == 0) ? tx0 : tx1;
  endfunction

  // Waits (bounded) for a start bit, then checks every cycle of the frame.
  task automatic capture(input int which, input int sb, output logic [7:0] b,
                         output int ts, output bit ok);
    int w;
    ok = 1'b1; b = 8'h00; ts = -1; w = 0;
    @(negedge clk);
    while (line(which) !== 1'b0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (line(which) !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    ts = cyc;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      if (line(which) !== 1'b0) ok = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (k == 0) b[i] = line(which);
        else if (line(which) !== b[i]) ok = 1'b0;
      end
    end
    for (int k = 0; k < sb * 8; k++) begin
      @(negedge clk);
      if (line(which) !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (tx0 !== 1'b1)   begin miscompares++; $display("FAIL reset_tx0 got %b want 1", tx0); end
    vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL reset_busy0 got %b want 0", busy0); end
    vectors++; if (cnt0 !== 5'd0)  begin miscompares++; $display("FAIL reset_cnt0 got %0d want 0", cnt0); end
    vectors++; if (rdy0 !== 1'b1)  begin miscompares++; $display("FAIL reset_rdy0 got %b want 1", rdy0); end
    vectors++; if (tx1 !== 1'b1 || busy1 !== 1'b0 || cnt1 !== 3'd0 || rdy1 !== 1'b1) begin
      miscompares++; $display("FAIL reset_u1 got tx=%b busy=%b cnt=%0d rdy=%b want 1 0 0 1", tx1, busy1, cnt1, rdy1);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    logic [7:0] b; int ts, t; bit ok;
    @(posedge clk); #1;
    vld0 = 1'b1; dat0 = 8'h55;
    @(posedge clk); #1;
    vld0 = 1'b0; t = cyc;
    vectors++; if (cnt0 !== 5'd1) begin miscompares++; $display("FAIL single_cnt got %0d want 1", cnt0); end
    capture(0, 1, b, ts, ok);
    vectors++; if (ts !== t + 1) begin miscompares++; $display("FAIL single_latency got %0d want %0d", ts, t + 1); end
    vectors++; if (b !== 8'h55 || !ok) begin miscompares++; $display("FAIL single_frame got %h ok=%0d want 55 ok=1", b, ok); end
    vectors++; if (busy0 !== 1'b1) begin miscompares++; $display("FAIL single_busy_last got %b want 1", busy0); end
    @(negedge clk);
    vectors++; if (busy0 !== 1'b0 || cyc !== ts + 80) begin
      miscompares++; $display("FAIL single_busy_drop got busy=%b at %0d want 0 at %0d", busy0, cyc, ts + 80);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b1, b2; int ts1, ts2; bit ok1, ok2;
    @(posedge clk); #1;
    vld0 = 1'b1; dat0 = 8'hA5;
    @(posedge clk); #1;
    dat0 = 8'h3C;
    @(posedge clk); #1;
    vld0 = 1'b0;
    capture(0, 1, b1, ts1, ok1);
    capture(0, 1, b2, ts2, ok2);
    vectors++; if (b1 !== 8'hA5 || !ok1) begin miscompares++; $display("FAIL b2b_first got %h ok=%0d want a5 ok=1", b1, ok1); end
    vectors++; if (b2 !== 8'h3C || !ok2) begin miscompares++; $display("FAIL b2b_second got %h ok=%0d want 3c ok=1", b2, ok2); end
    vectors++; if (ts2 !== ts1 + 80) begin miscompares++; $display("FAIL b2b_gap got start %0d want %0d", ts2, ts1 + 80); end
    @(negedge clk);
    vectors++; if (busy0 !== 1'b0 || cyc !== ts1 + 160) begin
      miscompares++; $display("FAIL b2b_total got busy=%b at %0d want 0 at %0d", busy0, cyc, ts1 + 160);
    end
  endtask

  task automatic test_fifo_full();
    int acc, ts0, lows;
    acc = 0; ts0 = 0; lows = 0;
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          vld0 = 1'b1; dat0 = 8'(i);
          if (rdy0) acc++;
          @(posedge clk); #1;
          if (i == 16) begin
            vectors++; if (cnt0 !== 5'd16 || rdy0 !== 1'b0) begin
              miscompares++; $display("FAIL full_level got cnt=%0d rdy=%b want 16 0", cnt0, rdy0);
            end
          end
        end
        vld0 = 1'b0;
      end
      begin
        logic [7:0] b; int ts; bit ok;
        for (int f = 0; f < 17; f++) begin
          capture(0, 1, b, ts, ok);
          if (f == 0) ts0 = ts;
          vectors++; if (b !== 8'(f) || !ok || ts !== ts0 + 80 * f) begin
            miscompares++; $display("FAIL full_frame%0d got %h ok=%0d start=%0d want %h ok=1 start=%0d", f, b, ok, ts, 8'(f), ts0 + 80 * f);
          end
        end
      end
    join
    vectors++; if (acc !== 17) begin miscompares++; $display("FAIL full_accepted got %0d want 17", acc); end
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (tx0 !== 1'b1) lows++;
    end
    vectors++; if (lows !== 0 || busy0 !== 1'b0) begin
      miscompares++; $display("FAIL full_no_extra got low_cycles=%0d busy=%b want 0 0", lows, busy0);
    end
  endtask

  task automatic test_reset_mid();
    int w, lows;
    w = 0; lows = 0;
    @(posedge clk); #1;
    vld0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      dat0 = (i == 0) ? 8'hFF : 8'(i);
      @(posedge clk); #1;
    end
    vld0 = 1'b0;
    vectors++; if (cnt0 !== 5'd4) begin miscompares++; $display("FAIL rstmid_queued got %0d want 4", cnt0); end
    @(negedge clk);
    while (tx0 !== 1'b0 && w < 200) begin @(negedge clk); w++; end
    repeat (35) @(negedge clk);
    vectors++; if (busy0 !== 1'b1) begin miscompares++; $display("FAIL rstmid_busy_before got %b want 1", busy0); end
    rst_n = 1'b0;
    #1;
    vectors++; if (tx0 !== 1'b1 || cnt0 !== 5'd0 || busy0 !== 1'b0 || rdy0 !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_during got tx=%b cnt=%0d busy=%b rdy=%b want 1 0 0 1", tx0, cnt0, busy0, rdy0);
    end
    repeat (3) @(negedge clk);
    if (tx0 !== 1'b1) lows++;
    rst_n = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || busy0 !== 1'b0) lows++;
    end
    vectors++; if (lows !== 0) begin miscompares++; $display("FAIL rstmid_after got bad_cycles=%0d want 0", lows); end
  endtask

  task automatic test_loopback();
    logic [7:0] exp_q [24];
    int bad, ts0;
    bad = 0; ts0 = 0;
    exp_q[0] = 8'h00; exp_q[1] = 8'hFF;
    for (int i = 2; i < 24; i++) exp_q[i] = 8'($urandom_range(0, 255));
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          int w;
          w = 0;
          vld0 = 1'b1; dat0 = exp_q[i];
          while (!rdy0 && w < 2000) begin @(posedge clk); #1; w++; end
          @(posedge clk); #1;
        end
        vld0 = 1'b0;
      end
      begin
        logic [7:0] b; int ts; bit ok;
        for (int f = 0; f < 24; f++) begin
          capture(0, 1, b, ts, ok);
          if (f == 0) ts0 = ts;
          if (b !== exp_q[f] || !ok || ts !== ts0 + 80 * f) begin
            bad++;
            $display("FAIL loop_frame%0d got %h ok=%0d start=%0d want %h ok=1 start=%0d", f, b, ok, ts, exp_q[f], ts0 + 80 * f);
          end
        end
      end
    join
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL loopback got %0d bad frames want 0", bad); end
  endtask

  task automatic test_stop2();
    logic [7:0] b; int ts, t; bit ok;
    @(posedge clk); #1;
    vld1 = 1'b1; dat1 = 8'h81;
    @(posedge clk); #1;
    vld1 = 1'b0; t = cyc;
    capture(1, 2, b, ts, ok);
    vectors++; if (b !== 8'h81 || !ok || ts !== t + 1) begin
      miscompares++; $display("FAIL stop2_frame got %h ok=%0d start=%0d want 81 ok=1 start=%0d", b, ok, ts, t + 1);
    end
    vectors++; if (busy1 !== 1'b1) begin miscompares++; $display("FAIL stop2_busy_last got %b want 1", busy1); end
    @(negedge clk);
    vectors++; if (busy1 !== 1'b0 || cyc !== ts + 88) begin
      miscompares++; $display("FAIL stop2_length got busy=%b at %0d want 0 at %0d", busy1, cyc, ts + 88);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_reset_mid();
    test_loopback();
    test_stop2();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
